// File: rtl/nvram_upload.sv
// nvram_upload: serves NVRAM bytes from the game's work RAM over the HPS upload path.
// It halts the CPU through pause_req/pause_ack and reads one byte per ioctl_rd. While a
// byte is being fetched, ioctl_wait holds the HPS off.
// Optional feature macro: NVRAM_CHECKSUM_EN. When it is defined, a read of address SIZE
// returns the ones' complement of the byte sum since the last address-0 read.
module nvram_upload #(
  parameter int unsigned SIZE         = 256,
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned UPLOAD_INDEX = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        pause_req,
  input  logic        pause_ack,
  output logic [11:0] ram_addr,
  output logic        ram_rd,
  input  logic [7:0]  ram_dout
);

  localparam logic [24:0] SizeW    = 25'(SIZE);
  localparam logic [7:0]  IndexW   = 8'(UPLOAD_INDEX);
  localparam logic [2:0]  RdLatCnt = 3'(RD_LAT);

  typedef enum logic [2:0] {StIdle, StPause, StReady, StRead, StLatch} state_e;

  state_e      state_q, state_d;
  logic [7:0]  din_q, din_d;
  logic        wait_q, wait_d;      // doubles as the "request pending" flag
  logic        preq_q, preq_d;
  logic [11:0] raddr_q, raddr_d;
  logic        rrd_q, rrd_d;
  logic [24:0] addr_q, addr_d;      // address of the pending request
  logic [2:0]  cnt_q, cnt_d;
`ifdef NVRAM_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  logic        active;
  logic        req_valid;
  logic [24:0] req_addr;

  assign active    = ioctl_upload && (ioctl_index == IndexW);
  // ioctl_rd while a request is pending is a protocol violation and is dropped.
  assign req_valid = wait_q || ioctl_rd;
  assign req_addr  = wait_q ? addr_q : ioctl_addr;

  // Next-state and output decode: abort has priority, then loss of the pause grant.
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    raddr_d = raddr_q;
    rrd_d   = 1'b0;
    cnt_d   = cnt_q;
`ifdef NVRAM_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (!active) begin
      // Session gone: abandon any in-flight read, keep ioctl_din as it was.
      state_d = StIdle;
      wait_d  = 1'b0;
    end else if (state_q != StIdle && !pause_ack) begin
      // CPU owns the RAM: park in PAUSE, still accepting one request to serve later.
      state_d = StPause;
      if (!wait_q && ioctl_rd) begin
        wait_d = 1'b1;
        addr_d = ioctl_addr;
      end
    end else begin
      unique case (state_q)
        // active can only be high here on its first cycle, so this is the rising edge.
        StIdle: state_d = StPause;
        StPause, StReady: begin
          state_d = StReady;
          if (req_valid) begin
            if (req_addr < SizeW) begin
              state_d = StRead;
              rrd_d   = 1'b1;
              raddr_d = req_addr[11:0];
              cnt_d   = RdLatCnt;
              wait_d  = 1'b1;
              addr_d  = req_addr;
`ifdef NVRAM_CHECKSUM_EN
              if (req_addr == '0) sum_d = 8'h00;
`endif
            end else begin
              wait_d = 1'b0;
              din_d  = 8'hFF;
`ifdef NVRAM_CHECKSUM_EN
              if (req_addr == SizeW) din_d = ~sum_q;
`endif
            end
          end
        end
        StRead: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = StLatch;
        end
        StLatch: begin
          state_d = StReady;
          din_d   = ram_dout;
          wait_d  = 1'b0;
`ifdef NVRAM_CHECKSUM_EN
          sum_d   = sum_q + ram_dout;
`endif
        end
        default: state_d = StIdle;
      endcase
    end
    preq_d = (state_d != StIdle);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= StIdle;
      din_q   <= 8'h00;
      wait_q  <= 1'b0;
      preq_q  <= 1'b0;
      raddr_q <= 12'h000;
      rrd_q   <= 1'b0;
      addr_q  <= 25'h0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      wait_q  <= wait_d;
      preq_q  <= preq_d;
      raddr_q <= raddr_d;
      rrd_q   <= rrd_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef NVRAM_CHECKSUM_EN
  // Running byte sum for the checksum read.
  always_ff @(posedge clk_sys) begin
    if (reset) sum_q <= 8'h00;
    else       sum_q <= sum_d;
  end
`endif

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign pause_req  = preq_q;
  assign ram_addr   = raddr_q;
  // Gate with the live grant so the strobe never reaches RAM the CPU has reclaimed.
  assign ram_rd     = rrd_q && pause_ack;

endmodule

// File: tb/tb_nvram_upload.sv
// Scoreboard bench for nvram_upload (SIZE=256, RD_LAT=2). Honours NVRAM_CHECKSUM_EN.
module tb_nvram_upload;

  localparam int unsigned SIZE   = 256;
  localparam int unsigned RD_LAT = 2;
`ifdef NVRAM_CHECKSUM_EN
  localparam logic [7:0] ExpSumXor = 8'h7F;  // sum of i^5A over 0..255 is 8'h80
  localparam logic [7:0] ExpSumTwo = 8'hFE;  // 255*1 + 2 = 257 -> 8'h01
`else
  localparam logic [7:0] ExpSumXor = 8'hFF;
  localparam logic [7:0] ExpSumTwo = 8'hFF;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        pause_req;
  logic        pause_ack = 1'b0;
  logic [11:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_dout;

  nvram_upload #(.SIZE(SIZE), .RD_LAT(RD_LAT), .UPLOAD_INDEX(4)) dut (
    .clk_sys      (clk),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .pause_req    (pause_req),
    .pause_ack    (pause_ack),
    .ram_addr     (ram_addr),
    .ram_rd       (ram_rd),
    .ram_dout     (ram_dout)
  );

  always #5 clk = ~clk;

  // RAM model: data valid exactly RD_LAT cycles after ram_rd, junk otherwise.
  logic [7:0]        mem [0:4095];
  logic [7:0]        dpipe [RD_LAT];
  logic [RD_LAT-1:0] vpipe = '0;
  always @(posedge clk) begin
    dpipe[0] <= mem[ram_addr];
    vpipe[0] <= ram_rd;
    for (int i = 1; i < RD_LAT; i++) begin
      dpipe[i] <= dpipe[i-1];
      vpipe[i] <= vpipe[i-1];
    end
  end
  assign ram_dout = vpipe[RD_LAT-1] ? dpipe[RD_LAT-1] : 8'hEE;

  int rd_cnt = 0;
  int viol   = 0;
  always @(posedge clk) if (ram_rd) rd_cnt <= rd_cnt + 1;
  always @(negedge clk) if (ram_rd && !pause_ack) viol <= viol + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         waits;
    int         tag;
  } exp_t;
  exp_t       sb[$];
  bit         mon_en = 1'b1;
  bit         mon_busy = 1'b0;
  int         mon_wcnt = 0;
  logic [7:0] last_din = 8'h00;

  // Monitor: follows the HPS side; after each ioctl_rd, waits for ioctl_wait low, then checks.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mon_busy) begin
        if (ioctl_wait) begin
          mon_wcnt++;
        end else begin
          mon_busy = 1'b0;
          if (sb.size() == 0) begin
            check("unexpected_response", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("din[%0d]", e.tag), int'(ioctl_din), int'(e.data));
            check($sformatf("wait_len[%0d]", e.tag), mon_wcnt, e.waits);
            last_din = e.data;
          end
        end
      end
      if (!mon_busy && ioctl_rd) begin
        mon_busy = 1'b1;
        mon_wcnt = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) begin
      check("response_timeout", 1, 0);
      sb.delete();
      mon_busy = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] d, input int w, input int tag);
    exp_t e;
    e.data = d; e.waits = w; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic do_read(input logic [24:0] a, input logic [7:0] d, input int w);
    push(d, w, int'(a));
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick(1);
    ioctl_rd   = 1'b0;
    drain();
  endtask

  task automatic dump();
    for (int i = 0; i < int'(SIZE); i++) do_read(25'(i), mem[i], RD_LAT + 1);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;

    // Reset values
    tick(3);
    check("rst_din", int'(ioctl_din), 0);
    check("rst_wait", int'(ioctl_wait), 0);
    check("rst_pause_req", int'(pause_req), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_ram_rd", int'(ram_rd), 0);
    reset = 1'b0;
    tick(1);

    // Wrong index: no response
    ioctl_index  = 8'd3;
    ioctl_upload = 1'b1;
    tick(3);
    check("wrong_index_pause_req", int'(pause_req), 0);
    ioctl_upload = 1'b0;
    tick(2);

    // Handshake: cycle 0 = active visible; ack at cycle 10; rd addr 0 at cycle 3
    ioctl_index  = 8'd4;
    ioctl_upload = 1'b1;
    check("hs_pause_req_c0", int'(pause_req), 0);
    tick(1);
    check("hs_pause_req_c1", int'(pause_req), 1);
    tick(2);
    push(mem[0], 10, 0);
    ioctl_addr = 25'd0;
    ioctl_rd   = 1'b1;
    tick(1);
    ioctl_rd   = 1'b0;
    check("hs_wait_c4", int'(ioctl_wait), 1);
    tick(6);
    check("hs_no_ram_rd_before_ack", rd_cnt, 0);
    pause_ack = 1'b1;
    drain();

    // Sequential dump with i^5A
    base = rd_cnt;
    dump();
    check("dump_ram_rd_pulses", rd_cnt - base, int'(SIZE));

    // Boundary and out-of-range reads: no RAM access, no wait
    base = rd_cnt;
    do_read(25'd256, ExpSumXor, 0);
    do_read(25'd300, 8'hFF, 0);
    do_read(25'd257, 8'hFF, 0);
    push(8'hFF, 0, 4096);
    push(8'hFF, 0, 16777216);
    ioctl_addr = 25'd4096;
    ioctl_rd   = 1'b1;
    tick(1);
    ioctl_addr = 25'h1000000;
    tick(1);
    ioctl_rd   = 1'b0;
    drain();
    check("oor_no_ram_rd", rd_cnt - base, 0);

    // Checksum: all 8'h01, then RAM[0]=8'h02
    for (int i = 0; i < 4096; i++) mem[i] = 8'h01;
    dump();
    do_read(25'd256, 8'hFF, 0);
    mem[0] = 8'h02;
    dump();
    do_read(25'd256, ExpSumTwo, 0);

    // Abort mid-read
    mon_en     = 1'b0;
    ioctl_addr = 25'd5;
    ioctl_rd   = 1'b1;
    tick(1);
    ioctl_rd   = 1'b0;
    check("abort_wait_before", int'(ioctl_wait), 1);
    check("abort_ram_rd_before", int'(ram_rd), 1);
    tick(1);
    ioctl_upload = 1'b0;
    tick(1);
    check("abort_pause_req", int'(pause_req), 0);
    check("abort_wait", int'(ioctl_wait), 0);
    check("abort_din_kept", int'(ioctl_din), int'(last_din));
    tick(3);
    check("abort_din_still_kept", int'(ioctl_din), int'(last_din));
    ioctl_upload = 1'b1;
    check("reassert_pause_req_c0", int'(pause_req), 0);
    tick(1);
    check("reassert_pause_req_c1", int'(pause_req), 1);
    tick(2);

    // Reset during the cycle before LATCH
    ioctl_addr = 25'd7;
    ioctl_rd   = 1'b1;
    tick(1);
    ioctl_rd   = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midrst_din", int'(ioctl_din), 0);
    check("midrst_wait", int'(ioctl_wait), 0);
    check("midrst_pause_req", int'(pause_req), 0);
    check("midrst_ram_rd", int'(ram_rd), 0);
    tick(2);

    check("ram_rd_without_ack", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
